// File: rtl/spi_master_ctrl_if.sv
// Command-side bus of spi_master_ctrl: host command request, read-back byte and status.
// Handshake: a command transfers on every rising clk edge where cmd_valid and cmd_ready
// are both high. The initiator holds cmd_op/cmd_data stable while cmd_valid is high and
// not yet accepted. cmd_ready never depends on cmd_valid. rd_data is qualified by the
// single-cycle rd_valid pulse and holds its value until the next pulse.
interface spi_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       err;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rd_data, rd_valid, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rd_data, rd_valid, busy, err
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: initiator-side SPI engine. Sends one 10-bit command frame
// {cmd_op, cmd_data} per SS_n-low window, preceded by a path-select bit, and for
// read-data frames shifts in the slave's reply byte from MISO. The slave samples
// on clk, so there is no SCLK.
// Optional feature macro: SPI_SEQ_CHECK_EN (refuse rd-data commands that were not
// preceded by a rd-addr frame and pulse err instead).
module spi_master_ctrl #(
  parameter int unsigned RD_WAIT  = 2,  // HOLD cycle to MISO bit7 valid, 1..15
  parameter int unsigned IDLE_GAP = 1   // SS_n high cycles after each frame, 1..15
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_ctrl_if.slave bus,
  output logic             SS_n,
  output logic             MOSI,
  input  logic             MISO,
  output logic [3:0]       o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_CMD   = 4'd2,
    S_SHIFT = 4'd3,
    S_HOLD  = 4'd4,
    S_WAIT  = 4'd5,
    S_RECV  = 4'd6,
    S_END   = 4'd7,
    S_ERR   = 4'd8
  } state_t;

  localparam logic [3:0] LP_WAIT_LAST = 4'(RD_WAIT - 2);
  localparam logic [3:0] LP_GAP_LAST  = 4'(IDLE_GAP - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [9:0] r_tx;
  logic [1:0] r_op;
  logic [7:0] r_shadow;
  logic [7:0] r_rd_data;
  logic       r_rd_valid;
  logic       r_busy;
  logic       r_err;
  logic       r_ss_n;
  logic       r_mosi;
  logic       w_accept;
  logic       w_block;

  assign bus.cmd_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept      = bus.cmd_valid & bus.cmd_ready;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;
  assign SS_n          = r_ss_n;
  assign MOSI          = r_mosi;
  assign o_dbg_state   = r_state;

`ifdef SPI_SEQ_CHECK_EN
  logic r_armed;

  // Track whether a rd-addr frame has completed since the last rd-data frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if ((r_state != S_END) && (w_next == S_END)) begin
      if (r_op == 2'b10)      r_armed <= 1'b1;
      else if (r_op == 2'b11) r_armed <= 1'b0;
    end
  end

  assign w_block = (bus.cmd_op == 2'b11) & ~r_armed;
`else
  assign w_block = 1'b0;
`endif

  // Next-state selection; the shared counter r_cnt restarts on every state change.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_block ? S_ERR : S_START;
      S_START: w_next = S_CMD;
      S_CMD:   w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == 4'd9) w_next = S_HOLD;
      S_HOLD: begin
        if (r_op != 2'b11)  w_next = S_END;
        else if (RD_WAIT > 1) w_next = S_WAIT;
        else                w_next = S_RECV;
      end
      S_WAIT:  if (r_cnt == LP_WAIT_LAST) w_next = S_RECV;
      S_RECV:  if (r_cnt == 4'd7) w_next = S_END;
      S_END:   if (r_cnt == LP_GAP_LAST) w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State/datapath registers; pin outputs are registered from the next state so
  // they line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_tx       <= 10'd0;
      r_op       <= 2'd0;
      r_shadow   <= 8'd0;
      r_rd_data  <= 8'd0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;

      // r_tx[9] is always the next bit to put on MOSI.
      if (w_accept) begin
        r_tx <= {bus.cmd_op, bus.cmd_data};
        r_op <= bus.cmd_op;
      end else if (w_next == S_SHIFT) begin
        r_tx <= {r_tx[8:0], 1'b0};
      end

      if (r_state == S_RECV) r_shadow <= {r_shadow[6:0], MISO};

      r_rd_valid <= (r_state == S_RECV) && (w_next == S_END);
      if ((r_state == S_RECV) && (w_next == S_END)) r_rd_data <= {r_shadow[6:0], MISO};

      r_busy <= (w_next != S_IDLE);
      r_err  <= (w_next == S_ERR);
      r_ss_n <= !(w_next inside {S_START, S_CMD, S_SHIFT, S_HOLD, S_WAIT, S_RECV});
      r_mosi <= ((w_next == S_CMD) || (w_next == S_SHIFT)) ? r_tx[9] : 1'b0;
    end
  end

endmodule
